// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one full-adder cell plus carry flop, WIDTH cycles per sum.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sa, sb, res, shifted;
  logic [CW-1:0] cnt;
  logic carry, s, nc, last;
  assign s = sa[0] ^ sb[0] ^ carry;
  assign nc = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
  assign shifted = {s, res[WIDTH-1:1]};
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state == SHIFT;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? SHIFT : IDLE;
      SHIFT:   state_nx = last ? DONE : SHIFT;
      default: state_nx = IDLE;
    endcase
  end
  // carry into the MSB is the pre-update carry on the final shift cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sa <= '0;
      sb <= '0;
      res <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && start) begin
      sa <= a;
      sb <= b;
      carry <= cin;
      cnt <= '0;
    end else if (state == SHIFT) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      carry <= nc;
      res <= shifted;
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) begin
        sum <= shifted;
        cout <= nc;
        ovf <= carry ^ nc;
      end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random and directed checks of serial_adder against an arithmetic reference model.
module tb_serial_adder;
  logic clk = 0, rst_n = 0, start = 0, cin = 0;
  logic [7:0] a = 0, b = 0;
  logic busy, done, cout, ovf;
  logic [7:0] sum;
  int n_checks = 0, n_fail = 0, cyc = 0, last_done = 0;
  logic [7:0] last_sum = 0;
  logic last_cout = 0, last_ovf = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: drop start after accept; 1: spam other operands during SHIFT/DONE; 2: hold start high
  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic c, input int mode, input string tag);
    int lat, bc, both;
    logic [8:0] full;
    logic exp_ovf;
    full = 9'(x) + 9'(y) + 9'(c);
    exp_ovf = (x[7] == y[7]) && (full[7] != x[7]);
    start = 1; a = x; b = y; cin = c;
    @(posedge clk); #1;
    lat = 0; bc = 0; both = 0;
    while (!done && lat < 20) begin
      if (mode == 0) begin start = 0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); end
      if (mode == 1) begin start = 1; a = 8'hAA; b = 8'h55; cin = 0; end
      if (busy) bc++;
      if (busy && done) both++;
      if (lat == 3) check({tag, " hold"}, {sum, cout, ovf}, {last_sum, last_cout, last_ovf});
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, 8);
    check({tag, " busy_cycles"}, bc, 8);
    check({tag, " busy_done_overlap"}, both, 0);
    check({tag, " sum"}, sum, full[7:0]);
    check({tag, " cout"}, cout, full[8]);
    check({tag, " ovf"}, ovf, exp_ovf);
    if (mode == 2 && last_done != 0) check({tag, " spacing"}, cyc - last_done, 10);
    last_done = cyc;
    last_sum = full[7:0]; last_cout = full[8]; last_ovf = exp_ovf;
    if (mode != 2) start = (mode == 1);
    @(posedge clk); #1;
    check({tag, " done_pulse"}, done, 0);
    if (mode == 1) begin
      start = 0;
      @(posedge clk); #1;
      check({tag, " no_second_op"}, busy, 0);
    end
    if (mode != 2) start = 0;
  endtask

  initial begin
    #1;
    check("reset outs", {busy, done, sum, cout, ovf}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    do_op(8'h0F, 8'h01, 0, 0, "t1");
    do_op(8'hFF, 8'h01, 0, 0, "t2a");
    do_op(8'hFF, 8'hFF, 1, 0, "t2b");
    do_op(8'h7F, 8'h01, 0, 0, "t3a");
    do_op(8'h80, 8'h80, 0, 0, "t3b");
    do_op(8'h12, 8'h34, 0, 1, "t4");
    last_done = 0;
    for (int i = 0; i < 3; i++) do_op(8'h01, 8'h01, 1, 2, "t5");
    start = 0;
    @(posedge clk); #1;
    // reset during the 4th SHIFT cycle
    start = 1; a = 8'hF0; b = 8'h0F; cin = 0;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1 check("t6 async_clear", {busy, done, sum, cout, ovf}, 0);
    begin
      int seen;
      seen = 0;
      @(negedge clk); rst_n = 1;
      repeat (12) begin @(posedge clk); #1; if (done || busy) seen++; end
      check("t6 no_done_after_reset", seen, 0);
    end
    last_sum = 0; last_cout = 0; last_ovf = 0;
    do_op(8'h05, 8'h03, 0, 0, "t6b");
    for (int i = 0; i < 20; i++) do_op(8'($urandom), 8'($urandom), 1'($urandom), 0, "rand");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
